conversion_d: RTL and testbench

- Single-bit D-type storage element built three independent ways: from an SR flip-flop core, a T flip-flop core and a JK flip-flop core.
- Each core has its own D-to-native input conversion logic.
- All three outputs must track the D input identically every cycle, so the block serves as a self-checking reference/teaching cell for flip-flop conversion.
- Leaf block; no handshakes.

---
 rtl/conversion_d.sv | 76 +++++++
 tb/tb_conversion_d.sv | 94 +++++++++
 2 files changed

// File: rtl/conversion_d.sv
// D-type storage cell built three ways: from SR, T and JK cores.
// All three outputs load d on every rising edge and must always agree.
module conversion_d #(
    parameter logic RESET_VAL = 1'b0
) (
    output logic qsr,
    output logic qt,
    output logic qjk,
    input  logic clk,
    input  logic reset,
    input  logic d
);

    logic qsr_q = RESET_VAL;
    logic qt_q  = RESET_VAL;
    logic qjk_q = RESET_VAL;
    logic qsr_d;
    logic qt_d;
    logic qjk_d;

    logic s;
    logic r;
    logic t;
    logic j;
    logic k;

    // D-to-native conversion; T uses its own Q so a steady d yields T=0
    assign s = d;
    assign r = ~d;
    assign t = d ^ qt_q;
    assign j = d;
    assign k = ~d;

    always_comb begin
        qsr_d = qsr_q;
        case ({s, r})
            2'b10:   qsr_d = 1'b1;
            2'b01:   qsr_d = 1'b0;
            default: qsr_d = qsr_q;
        endcase
    end

    always_comb begin
        qt_d = qt_q;
        if (t) begin
            qt_d = ~qt_q;
        end
    end

    always_comb begin
        qjk_d = qjk_q;
        case ({j, k})
            2'b10:   qjk_d = 1'b1;
            2'b01:   qjk_d = 1'b0;
            2'b11:   qjk_d = ~qjk_q;
            default: qjk_d = qjk_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qsr_q <= RESET_VAL;
            qt_q  <= RESET_VAL;
            qjk_q <= RESET_VAL;
        end else begin
            qsr_q <= qsr_d;
            qt_q  <= qt_d;
            qjk_q <= qjk_d;
        end
    end

    assign qsr = qsr_q;
    assign qt  = qt_q;
    assign qjk = qjk_q;

endmodule

// File: tb/tb_conversion_d.sv
// Bench for conversion_d: directed cases then random d/reset
// against a one-line golden model q_next = reset ? 0 : d.
module tb_conversion_d;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d = 1'b0;
    logic qsr;
    logic qt;
    logic qjk;

    int n_vec = 0;
    int n_bad = 0;
    logic exp_q = 1'b0;

    conversion_d #(.RESET_VAL(1'b0)) dut (
        .qsr   (qsr),
        .qt    (qt),
        .qjk   (qjk),
        .clk   (clk),
        .reset (reset),
        .d     (d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got,
                         input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".qsr"}, qsr, exp_q);
        check({tag, ".qt"},  qt,  exp_q);
        check({tag, ".qjk"}, qjk, exp_q);
    endtask

    // apply one cycle, then check; afterwards flip d and
    // confirm outputs do not move between edges
    task automatic step(input logic rv, input logic dv,
                        input string tag);
        reset = rv;
        d = dv;
        @(posedge clk);
        exp_q = rv ? 1'b0 : dv;
        #1;
        check_all(tag);
        d = ~d;
        reset = ~reset;
        #1;
        check_all({tag, ".hold"});
    endtask

    initial begin
        #1;
        check_all("powerup");

        step(0, 0, "pu_d0");
        step(0, 1, "pu_d1a");
        step(0, 1, "pu_d1b");

        step(1, 0, "rst_d0");
        step(0, 1, "post_rst_d1");

        step(1, 1, "rst_d1");
        step(0, 1, "post_rst1_d1");

        step(0, 1, "seq1");
        step(0, 0, "seq0");
        step(0, 1, "seq1b");
        step(0, 1, "seq1c");
        step(0, 1, "seq1d");

        step(1, 1, "alt_r1");
        step(0, 1, "alt_r0");
        step(1, 1, "alt_r1b");
        step(1, 1, "rst_b2b");
        step(0, 1, "first_load");

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
